// File: rtl/dbu_ctrl.sv
// Debug-unit controller for the multicycle CPU: run/step/breakpoint control of
// the CPU clock-enable, an inspection address counter and the display word mux.
module dbu_ctrl #(
  parameter int STATUS_W = 247,
  parameter int SIGNAL_W = 23,
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                succ,
  input  logic                step,
  input  logic                inc,
  input  logic                dec,
  input  logic [2:0]          sel,
  input  logic                m_rf,
  input  logic                brk_en,
  input  logic [WIDTH-1:0]    brk_pc,
  input  logic [STATUS_W-1:0] status,
  input  logic [WIDTH-1:0]    m_data,
  input  logic [WIDTH-1:0]    rf_data,
  output logic                run,
  output logic [ADDR_W-1:0]   m_rf_addr,
  output logic [WIDTH-1:0]    disp_data,
  output logic [SIGNAL_W-1:0] sgn_led,
  output logic                halted
);

  typedef enum logic [1:0] {IDLE, STEP, CONT, HALT} state_t;

  state_t state_r, state_nx;

  logic [SIGNAL_W-1:0] sgn;
  logic [WIDTH-1:0]    next_pc, pc, ir, rd0, rd1, alu_out, mdr;

  assign sgn     = status[STATUS_W-1 -: SIGNAL_W];
  assign next_pc = status[7*WIDTH-1 -: WIDTH];
  assign pc      = status[6*WIDTH-1 -: WIDTH];
  assign ir      = status[5*WIDTH-1 -: WIDTH];
  assign rd0     = status[4*WIDTH-1 -: WIDTH];
  assign rd1     = status[3*WIDTH-1 -: WIDTH];
  assign alu_out = status[2*WIDTH-1 -: WIDTH];
  assign mdr     = status[WIDTH-1:0];

  // Three-stage chains, bit order {dec, inc, step, succ}; stage 2 is the
  // synchronized level and stage 3 only serves rising-edge detection.
  logic [3:0] sync_q [0:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q[0] <= '0;
      sync_q[1] <= '0;
      sync_q[2] <= '0;
    end else begin
      sync_q[0] <= {dec, inc, step, succ};
      sync_q[1] <= sync_q[0];
      sync_q[2] <= sync_q[1];
    end
  end

  logic       succ_s;
  logic [2:0] pulse;
  logic       step_p, inc_p, dec_p;
  logic       hit;

  assign succ_s = sync_q[1][0];
  assign pulse  = sync_q[1][3:1] & ~sync_q[2][3:1];
  assign step_p = pulse[0];
  assign inc_p  = pulse[1];
  assign dec_p  = pulse[2];
  assign hit    = brk_en & (pc == brk_pc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      halted  <= 1'b0;
    end else begin
      state_r <= state_nx;
      halted  <= (state_nx == HALT);
    end
  end

  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (succ_s)      state_nx = CONT;
        else if (step_p) state_nx = STEP;
      end
      STEP: state_nx = IDLE;
      CONT: begin
        if (!succ_s)     state_nx = IDLE;
        else if (hit)    state_nx = HALT;
      end
      HALT: begin
        if (step_p)      state_nx = STEP;
        else if (!succ_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Gating run on hit freezes the CPU in the very cycle the breakpoint PC shows up.
  always_comb begin
    run = 1'b0;
    case (state_r)
      STEP:    run = 1'b1;
      CONT:    run = ~hit;
      default: run = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rf_addr <= '0;
    end else if (inc_p && !dec_p) begin
      m_rf_addr <= m_rf_addr + ADDR_W'(1);
    end else if (dec_p && !inc_p) begin
      m_rf_addr <= m_rf_addr - ADDR_W'(1);
    end
  end

  logic [WIDTH-1:0] disp_nx;

  always_comb begin
    disp_nx = '0;
    case (sel)
      3'd0:    disp_nx = m_rf ? m_data : rf_data;
      3'd1:    disp_nx = next_pc;
      3'd2:    disp_nx = pc;
      3'd3:    disp_nx = ir;
      3'd4:    disp_nx = rd0;
      3'd5:    disp_nx = rd1;
      3'd6:    disp_nx = alu_out;
      3'd7:    disp_nx = mdr;
      default: disp_nx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_data <= '0;
      sgn_led   <= '0;
    end else begin
      disp_data <= disp_nx;
      sgn_led   <= sgn;
    end
  end

endmodule

// File: tb/tb_dbu_ctrl.sv
// Directed testbench for dbu_ctrl: display-mux vector table plus hand-written
// sequences for reset, stepping, continuous run, breakpoints and the address counter.
module tb_dbu_ctrl;

  localparam int STATUS_W = 247;
  localparam int SIGNAL_W = 23;
  localparam int WIDTH    = 32;
  localparam int ADDR_W   = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                succ = 1'b0, step = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [2:0]          sel = 3'd0;
  logic                m_rf = 1'b0;
  logic                brk_en = 1'b0;
  logic [WIDTH-1:0]    brk_pc = '0;
  logic [STATUS_W-1:0] status = '0;
  logic [WIDTH-1:0]    m_data = '0;
  logic [WIDTH-1:0]    rf_data = '0;
  logic                run;
  logic [ADDR_W-1:0]   m_rf_addr;
  logic [WIDTH-1:0]    disp_data;
  logic [SIGNAL_W-1:0] sgn_led;
  logic                halted;

  int checks = 0;
  int failures = 0;

  dbu_ctrl #(
    .STATUS_W(STATUS_W), .SIGNAL_W(SIGNAL_W), .WIDTH(WIDTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .succ(succ), .step(step), .inc(inc), .dec(dec),
    .sel(sel), .m_rf(m_rf), .brk_en(brk_en), .brk_pc(brk_pc), .status(status),
    .m_data(m_data), .rf_data(rf_data), .run(run), .m_rf_addr(m_rf_addr),
    .disp_data(disp_data), .sgn_led(sgn_led), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic        m_rf;
    logic [22:0] sgn;
    logic [31:0] npc, pc, ir, rd0, rd1, alu, mdr, mdata, rfdata;
    logic [31:0] exp_disp;
  } disp_vec_t;

  disp_vec_t vecs [0:8];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [STATUS_W-1:0] pack_status(
      input logic [22:0] sgn, input logic [31:0] npc, input logic [31:0] pc,
      input logic [31:0] ir, input logic [31:0] rd0, input logic [31:0] rd1,
      input logic [31:0] alu, input logic [31:0] mdr);
    return {sgn, npc, pc, ir, rd0, rd1, alu, mdr};
  endfunction

  task automatic set_pc(input logic [31:0] v);
    status[191:160] = v;
  endtask

  task automatic apply_stimulus(input disp_vec_t v);
    sel     = v.sel;
    m_rf    = v.m_rf;
    m_data  = v.mdata;
    rf_data = v.rfdata;
    status  = pack_status(v.sgn, v.npc, v.pc, v.ir, v.rd0, v.rd1, v.alu, v.mdr);
  endtask

  task automatic press(input logic i_v, input logic d_v, input int hold);
    inc = i_v;
    dec = d_v;
    tick(hold);
    inc = 1'b0;
    dec = 1'b0;
    tick(3);
  endtask

  initial begin
    vecs[0] = '{3'd2, 1'b0, 23'h7FFFFF, 32'h44, 32'h40, 32'h00A00093, 32'h11, 32'h22, 32'h33, 32'h44, 32'hDEADBEEF, 32'd5, 32'h40};
    vecs[1] = '{3'd0, 1'b1, 23'h000001, 32'h104, 32'h100, 32'h00A00093, 32'h11, 32'h22, 32'h33, 32'h44, 32'hDEADBEEF, 32'd5, 32'hDEADBEEF};
    vecs[2] = '{3'd0, 1'b0, 23'h2AAAAA, 32'h104, 32'h100, 32'h00A00093, 32'h11, 32'h22, 32'h33, 32'h44, 32'hDEADBEEF, 32'd5, 32'd5};
    vecs[3] = '{3'd1, 1'b0, 23'h555555, 32'h104, 32'h100, 32'h00A00093, 32'h11, 32'h22, 32'h33, 32'h44, 32'hDEADBEEF, 32'd5, 32'h104};
    vecs[4] = '{3'd3, 1'b1, 23'h123456, 32'h104, 32'h100, 32'h00A00093, 32'h11, 32'h22, 32'h33, 32'h44, 32'hDEADBEEF, 32'd5, 32'h00A00093};
    vecs[5] = '{3'd4, 1'b0, 23'h000000, 32'h104, 32'h100, 32'h00A00093, 32'h11, 32'h22, 32'h33, 32'h44, 32'hDEADBEEF, 32'd5, 32'h11};
    vecs[6] = '{3'd5, 1'b0, 23'h400000, 32'h104, 32'h100, 32'h00A00093, 32'h11, 32'h22, 32'h33, 32'h44, 32'hDEADBEEF, 32'd5, 32'h22};
    vecs[7] = '{3'd6, 1'b1, 23'h00FF00, 32'h104, 32'h100, 32'h00A00093, 32'h11, 32'h22, 32'h33, 32'h44, 32'hDEADBEEF, 32'd5, 32'h33};
    vecs[8] = '{3'd7, 1'b0, 23'h0F0F0F, 32'h104, 32'h100, 32'h00A00093, 32'h11, 32'h22, 32'h33, 32'h44, 32'hDEADBEEF, 32'd5, 32'h44};

    // Reset held while inputs wiggle: nothing may leak through.
    #2 rst = 1'b0;
    status = pack_status(23'h7FFFFF, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7);
    sel = 3'd2;
    for (int i = 0; i < 4; i++) begin
      succ = ~succ;
      step = ~step;
      tick(1);
      check_output($sformatf("reset_run_%0d", i), 32'(run), 32'd0);
    end
    check_output("reset_addr", 32'(m_rf_addr), 32'd0);
    check_output("reset_disp", disp_data, 32'd0);
    check_output("reset_halted", 32'(halted), 32'd0);
    check_output("reset_sgn", 32'(sgn_led), 32'd0);
    succ = 1'b0;
    step = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(4);
    check_output("post_reset_idle_run", 32'(run), 32'd0);

    // Display mux table, one-cycle latency.
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      if (i > 0) check_output($sformatf("disp_hold_%0d", i), disp_data, vecs[i-1].exp_disp);
      tick(1);
      check_output($sformatf("disp_vec_%0d", i), disp_data, vecs[i].exp_disp);
      check_output($sformatf("sgn_vec_%0d", i), 32'(sgn_led), 32'(vecs[i].sgn));
    end

    // Single step: run high only at the third edge after the press, twice.
    for (int p = 0; p < 2; p++) begin
      step = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        tick(1);
        check_output($sformatf("step%0d_run_e%0d", p, i), 32'(run), 32'(i == 3));
      end
      step = 1'b0;
      tick(4);
    end

    // Continuous run with breakpoint PC present but disabled; step ignored.
    brk_en = 1'b0;
    brk_pc = 32'hC;
    set_pc(32'hC);
    succ = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      check_output($sformatf("cont_run_e%0d", i), 32'(run), 32'(i >= 3));
    end
    step = 1'b1;
    tick(5);
    check_output("cont_step_ignored", 32'(run), 32'd1);
    step = 1'b0;
    tick(3);
    check_output("cont_after_step", 32'(run), 32'd1);
    succ = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      check_output($sformatf("cont_stop_e%0d", i), 32'(run), 32'(i < 3));
    end

    // Breakpoint at PC 0xC, then step past it.
    brk_en = 1'b1;
    set_pc(32'h0);
    succ = 1'b1;
    tick(3);
    check_output("brk_run_pc0", 32'(run), 32'd1);
    set_pc(32'h4);
    tick(1);
    check_output("brk_run_pc4", 32'(run), 32'd1);
    set_pc(32'h8);
    tick(1);
    check_output("brk_run_pc8", 32'(run), 32'd1);
    set_pc(32'hC);
    #1;
    check_output("brk_run_drop", 32'(run), 32'd0);
    check_output("brk_halted_pre", 32'(halted), 32'd0);
    tick(1);
    check_output("brk_halted", 32'(halted), 32'd1);
    check_output("brk_run_halt", 32'(run), 32'd0);
    tick(1);
    check_output("brk_halt_stays", 32'(halted), 32'd1);
    step = 1'b1;
    tick(2);
    check_output("brk_wait_run", 32'(run), 32'd0);
    check_output("brk_wait_halted", 32'(halted), 32'd1);
    tick(1);
    check_output("brk_step_run", 32'(run), 32'd1);
    check_output("brk_step_halted", 32'(halted), 32'd0);
    set_pc(32'h10);
    tick(1);
    check_output("brk_idle_run", 32'(run), 32'd0);
    tick(1);
    check_output("brk_recont_run", 32'(run), 32'd1);
    check_output("brk_recont_halted", 32'(halted), 32'd0);
    step = 1'b0;
    succ = 1'b0;
    brk_en = 1'b0;
    tick(3);
    check_output("brk_final_idle", 32'(run), 32'd0);

    // Address counter wrap, held button, simultaneous inc/dec.
    press(1'b0, 1'b1, 4);
    check_output("addr_dec_wrap", 32'(m_rf_addr), 32'hFF);
    press(1'b1, 1'b0, 4);
    check_output("addr_inc_wrap", 32'(m_rf_addr), 32'h00);
    press(1'b1, 1'b0, 10);
    check_output("addr_inc_held", 32'(m_rf_addr), 32'h01);
    press(1'b1, 1'b1, 4);
    check_output("addr_both", 32'(m_rf_addr), 32'h01);

    // Reset mid-operation with a step press in flight.
    succ = 1'b1;
    tick(4);
    check_output("midrst_cont_run", 32'(run), 32'd1);
    step = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    check_output("midrst_run", 32'(run), 32'd0);
    check_output("midrst_halted", 32'(halted), 32'd0);
    check_output("midrst_addr", 32'(m_rf_addr), 32'd0);
    check_output("midrst_disp", disp_data, 32'd0);
    succ = 1'b0;
    step = 1'b0;
    tick(2);
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      check_output($sformatf("midrst_idle_e%0d", i), 32'(run), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
